// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//
// Packs Ratio consecutive narrow beats (InWidth bits each) into one wide word
// (InWidth*Ratio bits). Lane 0 (LSBs) holds the first beat of a word. An early
// in_last_i flushes a partial word; unwritten lanes read 0 and out_keep_o marks
// the lanes that hold valid beats (always contiguous from lane 0).
//
// Both sides use valid/ready handshakes. A completed word goes straight into the
// output register when that register is free or draining. Otherwise the word is
// parked in the assembly register and the input is stalled until it moves out.
//
// Ports:
//   clk_i        in   clock, rising-edge active
//   reset_ni     in   asynchronous active-low reset
//   in_valid_i   in   input beat valid
//   in_ready_o   out  block can accept an input beat (registered: !pending)
//   in_data_i    in   [InWidth-1:0] input beat data
//   in_last_i    in   beat ends a packet
//   out_valid_o  out  output word valid
//   out_ready_i  in   consumer accepts output word
//   out_data_o   out  [InWidth*Ratio-1:0] packed word
//   out_keep_o   out  [Ratio-1:0] per-lane valid mask
//   out_last_o   out  word ends a packet
// -----------------------------------------------------------------------------
module stream_upsizer #(
    parameter int InWidth = 8,
    parameter int Ratio   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [InWidth-1:0]         in_data_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [InWidth*Ratio-1:0]   out_data_o,
    output logic [Ratio-1:0]           out_keep_o,
    output logic                       out_last_o
);

    localparam int WordW = InWidth * Ratio;
    localparam int IdxW  = (Ratio > 1) ? $clog2(Ratio) : 1;

    // Assembly side
    logic [WordW-1:0] r_asm_data;
    logic [Ratio-1:0] r_asm_keep;
    logic             r_asm_last;
    logic [IdxW-1:0]  r_idx;
    logic             r_pending;

    // Output register
    logic [WordW-1:0] r_out_data;
    logic [Ratio-1:0] r_out_keep;
    logic             r_out_last;
    logic             r_out_valid;

    // Word as it looks with the current beat merged into lane r_idx
    logic [WordW-1:0] w_word_data;
    logic [Ratio-1:0] w_word_keep;
    logic [Ratio-1:0] w_lane_sel;

    logic w_in_fire;
    logic w_at_last_lane;
    logic w_complete;
    logic w_out_free;
    logic w_drain_pending;
    logic w_load_direct;
    logic w_load_out;

    genvar gi;
    generate
        for (gi = 0; gi < Ratio; gi++) begin : g_lane
            assign w_lane_sel[gi] = (r_idx == IdxW'(gi));
            assign w_word_data[gi*InWidth +: InWidth] =
                w_lane_sel[gi] ? in_data_i : r_asm_data[gi*InWidth +: InWidth];
            assign w_word_keep[gi] = w_lane_sel[gi] | r_asm_keep[gi];
        end
    endgenerate

    assign w_in_fire       = in_valid_i & ~r_pending;
    assign w_at_last_lane  = (r_idx == IdxW'(Ratio - 1));
    assign w_complete      = w_in_fire & (w_at_last_lane | in_last_i);
    assign w_out_free      = ~r_out_valid | out_ready_i;
    // A pending word only exists while the output register is occupied, so
    // out_ready_i alone means the output slot drains this edge.
    assign w_drain_pending = r_pending & out_ready_i;
    // No beat is accepted while pending, so the two load sources are exclusive.
    assign w_load_direct   = w_complete & w_out_free;
    assign w_load_out      = w_drain_pending | w_load_direct;

    // Output register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_drain_pending) begin
                r_out_data <= r_asm_data;
                r_out_keep <= r_asm_keep;
                r_out_last <= r_asm_last;
            end else if (w_load_direct) begin
                r_out_data <= w_word_data;
                r_out_keep <= w_word_keep;
                r_out_last <= in_last_i;
            end

            if (w_load_out) begin
                r_out_valid <= 1'b1;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Assembly register, lane index and pending flag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_asm_data <= '0;
            r_asm_keep <= '0;
            r_asm_last <= 1'b0;
            r_idx      <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_drain_pending || w_load_direct) begin
                // Word handed to the output register: start a fresh one.
                r_asm_data <= '0;
                r_asm_keep <= '0;
                r_asm_last <= 1'b0;
                r_idx      <= '0;
                r_pending  <= 1'b0;
            end else if (w_complete) begin
                // Output slot busy: park the finished word here.
                r_asm_data <= w_word_data;
                r_asm_keep <= w_word_keep;
                r_asm_last <= in_last_i;
                r_idx      <= '0;
                r_pending  <= 1'b1;
            end else if (w_in_fire) begin
                r_asm_data <= w_word_data;
                r_asm_keep <= w_word_keep;
                r_idx      <= r_idx + IdxW'(1);
            end
        end
    end

    assign in_ready_o  = ~r_pending;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_keep_o  = r_out_keep;
    assign out_last_o  = r_out_last;

endmodule

// File: tb/tb_stream_upsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_upsizer
//
// Checks stream_upsizer (InWidth=8, Ratio=4) against a packet-level model:
// accepted beats are gathered into words (Ratio beats or an early last), and the
// words completed but not yet consumed form an ordered queue. Every cycle the
// DUT outputs are compared with the head of that queue, out_valid_o with
// "queue non-empty", and in_ready_o with "fewer than two words in flight".
// Directed cases pin the model with literal words; a random phase adds
// valid/ready backpressure over 1000 beats.
// -----------------------------------------------------------------------------
module tb_stream_upsizer;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int WW = W * R;

    logic          clk;
    logic          reset_ni;
    logic          in_valid;
    logic          in_ready_o;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid_o;
    logic          out_ready;
    logic [WW-1:0] out_data_o;
    logic [R-1:0]  out_keep_o;
    logic          out_last_o;

    stream_upsizer #(.InWidth(W), .Ratio(R)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready),
        .out_data_o (out_data_o),
        .out_keep_o (out_keep_o),
        .out_last_o (out_last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [WW-1:0] q_d[$];
    logic [R-1:0]  q_k[$];
    logic          q_l[$];
    logic [WW-1:0] m_data;
    int            m_cnt;

    // Words the DUT actually handed over, for literal checks
    logic [WW-1:0] log_d[$];
    logic [R-1:0]  log_k[$];
    logic          log_l[$];

    logic          prev_hold;
    logic [WW-1:0] prev_d;
    logic [R-1:0]  prev_k;
    logic          prev_l;

    always @(negedge clk) begin
        if (!reset_ni) begin
            q_d.delete(); q_k.delete(); q_l.delete();
            m_data    = '0;
            m_cnt     = 0;
            prev_hold = 1'b0;
        end else begin
            check("out_valid", 64'(out_valid_o), 64'(q_d.size() > 0));
            check("in_ready", 64'(in_ready_o), 64'(q_d.size() < 2));
            if (out_valid_o && q_d.size() > 0) begin
                check("out_data", 64'(out_data_o), 64'(q_d[0]));
                check("out_keep", 64'(out_keep_o), 64'(q_k[0]));
                check("out_last", 64'(out_last_o), 64'(q_l[0]));
            end
            if (prev_hold) begin
                check("hold_data", 64'(out_data_o), 64'(prev_d));
                check("hold_keep", 64'(out_keep_o), 64'(prev_k));
                check("hold_last", 64'(out_last_o), 64'(prev_l));
            end
            prev_hold = out_valid_o && !out_ready;
            prev_d    = out_data_o;
            prev_k    = out_keep_o;
            prev_l    = out_last_o;

            if (out_valid_o && out_ready) begin
                log_d.push_back(out_data_o);
                log_k.push_back(out_keep_o);
                log_l.push_back(out_last_o);
                if (q_d.size() > 0) begin
                    void'(q_d.pop_front());
                    void'(q_k.pop_front());
                    void'(q_l.pop_front());
                end
            end
            if (in_valid && in_ready_o) begin
                m_data = m_data | (WW'(in_data) << (m_cnt * W));
                m_cnt++;
                if (m_cnt == R || in_last) begin
                    q_d.push_back(m_data);
                    q_k.push_back(R'((1 << m_cnt) - 1));
                    q_l.push_back(in_last);
                    m_data = '0;
                    m_cnt  = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready_o;
            tick();
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic check_log(input string name, input int i, input logic [WW-1:0] d,
                             input logic [R-1:0] k, input logic l);
        if (i < log_d.size()) begin
            check({name, "_data"}, 64'(log_d[i]), 64'(d));
            check({name, "_keep"}, 64'(log_k[i]), 64'(k));
            check({name, "_last"}, 64'(log_l[i]), 64'(l));
        end else begin
            check({name, "_missing"}, 64'(log_d.size()), 64'(i + 1));
        end
    endtask

    initial begin
        int n0;
        reset_ni  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_data", 64'(out_data_o), 64'd0);
        check("rst_out_keep", 64'(out_keep_o), 64'd0);
        check("rst_out_last", 64'(out_last_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #2 reset_ni = 1'b1;
        idle(2);

        // Full word, back-to-back beats
        n0 = log_d.size();
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        check("t1_no_early_valid", 64'(out_valid_o), 64'd0);
        send_beat(8'h44, 1'b0);
        check("t1_latency", 64'(out_valid_o), 64'd1);
        idle(3);
        check_log("t1", n0, 32'h44332211, 4'hF, 1'b0);
        check("t1_count", 64'(log_d.size()), 64'(n0 + 1));

        // Early last flushes a partial word; next beat restarts at lane 0
        n0 = log_d.size();
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        send_beat(8'hCC, 1'b0);
        send_beat(8'hDD, 1'b1);
        idle(3);
        check_log("t2a", n0, 32'h0000BBAA, 4'h3, 1'b1);
        check_log("t2b", n0 + 1, 32'h0000DDCC, 4'h3, 1'b1);

        // Single-beat packet
        n0 = log_d.size();
        send_beat(8'h5A, 1'b1);
        idle(3);
        check_log("t3", n0, 32'h0000005A, 4'h1, 1'b1);

        // Backpressure: output full + pending stalls the input
        n0 = log_d.size();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'(8'h30 + i), 1'b0);
        check("t4_stalled", 64'(in_ready_o), 64'd0);
        check("t4_held_word", 64'(out_data_o), 64'h33323130);
        idle(5);
        out_ready = 1'b1;
        for (int i = 8; i < 12; i++) send_beat(8'(8'h30 + i), 1'b0);
        idle(4);
        check_log("t4a", n0, 32'h33323130, 4'hF, 1'b0);
        check_log("t4b", n0 + 1, 32'h37363534, 4'hF, 1'b0);
        check_log("t4c", n0 + 2, 32'h3B3A3938, 4'hF, 1'b0);
        check("t4_count", 64'(log_d.size()), 64'(n0 + 3));
        check("t4_ready_back", 64'(in_ready_o), 64'd1);

        // Asynchronous reset mid-operation discards held and partial words
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'(8'hF1 + i), 1'b0);
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        #3 reset_ni = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid_o), 64'd0);
        check("t5_rst_data", 64'(out_data_o), 64'd0);
        check("t5_rst_keep", 64'(out_keep_o), 64'd0);
        check("t5_rst_last", 64'(out_last_o), 64'd0);
        check("t5_rst_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        #2 reset_ni = 1'b1;
        out_ready = 1'b1;
        idle(1);
        n0 = log_d.size();
        for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0);
        idle(3);
        check_log("t5", n0, 32'h04030201, 4'hF, 1'b0);
        check("t5_count", 64'(log_d.size()), 64'(n0 + 1));

        // Random backpressure, random packet boundaries
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat(8'($urandom), ($urandom_range(0, 5) == 0));
        end
        send_beat(8'hEE, 1'b1);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && (q_d.size() != 0 || out_valid_o); c++) idle(1);
        idle(1);
        check("drain_queue", 64'(q_d.size()), 64'd0);
        check("drain_valid", 64'(out_valid_o), 64'd0);
        check("drain_partial", 64'(m_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
